// File: rtl/mem_stage_if.sv
// Data-bus interface between the memory stage and the memory system.
// Latency: none; this only bundles the request/acknowledge wires.
// Backpressure: mem_req stays high until a single-cycle mem_ack completes the access.
//
// Signals:
//   mem_req   - access request, high for the whole outstanding access
//   mem_we    - 1 = store, 0 = load
//   mem_addr  - word-aligned address (low two bits are 0)
//   mem_be    - byte enables, little-endian lanes
//   mem_wdata - store data, replicated across lanes
//   mem_rdata - read data, valid together with mem_ack
//   mem_ack   - single-cycle completion pulse
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and the register-file write port.
// Latency: 1 cycle for non-memory results; loads take 2+ cycles (entry edge, then ack edge).
// Backpressure: stall_req holds upstream while a bus access is outstanding; released on the
//               ack cycle or the timeout cycle.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid .. in_sdata     - instruction from execute (register write info, memop, address, store data)
//   stall_req                - upstream must hold its outputs this cycle
//   bus                      - data-bus master (mem_req/we/addr/be/wdata out, mem_rdata/ack in)
//   wb_we/wb_waddr/wb_wdata  - registered register-file write port
//   exc_misalign/exc_buserr  - one-cycle exception pulses
//   exc_badaddr              - faulting byte address, held until the next exception
module mem_stage #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    input  logic        in_wreg,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_memop,
    input  logic [31:0] in_maddr,
    input  logic [31:0] in_sdata,

    output logic        stall_req,

    mem_stage_if.master bus,

    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,

    output logic        exc_misalign,
    output logic        exc_buserr,
    output logic [31:0] exc_badaddr
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Counter is sized to hold TIMEOUT itself; one bit when the timeout is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    // Access captured on BUSY entry; upstream is stalled but we do not rely on it holding.
    logic [3:0]    cap_op;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_sdata;
    logic [4:0]    cap_waddr;
    logic          cap_wreg;
    logic [CW-1:0] tmo_cnt;

    logic          in_is_load;
    logic          in_is_store;
    logic          in_is_mem;
    logic          in_misalign;
    logic          accept_mem;
    logic          tmo_hit;
    logic          cap_is_load;
    logic          cap_is_store;
    logic          req;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // ------------------------------------------------------------------
    // Input decode. Codes 9..15 fall outside both ranges and act as "none".
    // ------------------------------------------------------------------
    assign in_is_load  = (in_memop >= OP_LB) && (in_memop <= OP_LW);
    assign in_is_store = (in_memop >= OP_SB) && (in_memop <= OP_SW);
    assign in_is_mem   = in_is_load || in_is_store;

    always_comb begin
        in_misalign = 1'b0;
        case (in_memop)
            OP_LH, OP_LHU, OP_SH: in_misalign = in_maddr[0];
            OP_LW, OP_SW:         in_misalign = (in_maddr[1:0] != 2'b00);
            default:              in_misalign = 1'b0;
        endcase
    end

    assign accept_mem   = (state == IDLE) && in_valid && in_is_mem && !in_misalign;

    assign cap_is_load  = (cap_op >= OP_LB) && (cap_op <= OP_LW);
    assign cap_is_store = (cap_op >= OP_SB) && (cap_op <= OP_SW);

    // Timeout fires on the BUSY cycle in which the counter has already reached TIMEOUT;
    // in that cycle the request is withdrawn and any ack is disregarded.
    assign tmo_hit = (TIMEOUT > 0) && (state == BUSY) && (tmo_cnt == CW'(TIMEOUT));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                if (accept_mem) begin
                    state_nx  = BUSY;
                    stall_req = 1'b1;
                end
            end
            BUSY: begin
                if (tmo_hit || bus.mem_ack) begin
                    state_nx = IDLE;
                end else begin
                    stall_req = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // While reset is held the upstream may still present a memop; do not stall it.
        if (rst) begin
            stall_req = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bus drive: qualified by the request so the bus is quiet when idle.
    // ------------------------------------------------------------------
    assign req = (state == BUSY) && !tmo_hit;

    always_comb begin
        bus.mem_req   = req;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'd0;
        if (req) begin
            bus.mem_we   = cap_is_store;
            bus.mem_addr = {cap_addr[31:2], 2'b00};
            case (cap_op)
                OP_SB: begin
                    bus.mem_be    = 4'b0001 << cap_addr[1:0];
                    bus.mem_wdata = {4{cap_sdata[7:0]}};
                end
                OP_SH: begin
                    bus.mem_be    = 4'b0011 << cap_addr[1:0];
                    bus.mem_wdata = {2{cap_sdata[15:0]}};
                end
                OP_SW: begin
                    bus.mem_be    = 4'b1111;
                    bus.mem_wdata = cap_sdata;
                end
                default: begin
                    bus.mem_be    = 4'b1111;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction (little-endian lanes).
    // ------------------------------------------------------------------
    always_comb begin
        case (cap_addr[1:0])
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = cap_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (cap_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, writeback, exceptions, timeout counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_op       <= 4'd0;
            cap_addr     <= 32'd0;
            cap_sdata    <= 32'd0;
            cap_waddr    <= 5'd0;
            cap_wreg     <= 1'b0;
            tmo_cnt      <= '0;
            wb_we        <= 1'b0;
            wb_waddr     <= 5'd0;
            wb_wdata     <= 32'd0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
            exc_badaddr  <= 32'd0;
        end else begin
            // Writes and exceptions are single-cycle unless re-armed below.
            wb_we        <= 1'b0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_is_mem) begin
                            wb_we    <= in_wreg;
                            wb_waddr <= in_waddr;
                            wb_wdata <= in_wdata;
                        end else if (in_misalign) begin
                            exc_misalign <= 1'b1;
                            exc_badaddr  <= in_maddr;
                        end else begin
                            cap_op    <= in_memop;
                            cap_addr  <= in_maddr;
                            cap_sdata <= in_sdata;
                            cap_waddr <= in_waddr;
                            cap_wreg  <= in_wreg;
                            tmo_cnt   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (tmo_hit) begin
                        exc_buserr  <= 1'b1;
                        exc_badaddr <= cap_addr;
                    end else if (bus.mem_ack) begin
                        if (cap_is_load) begin
                            wb_we    <= cap_wreg;
                            wb_waddr <= cap_waddr;
                            wb_wdata <= ld_data;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage placed between execute and the register file write port.
- Non-memory results pass through to writeback with a one-cycle register.
- Loads and stores run through a req/ack data-bus handshake. The stage stalls upstream while an access is outstanding.
- Registered outputs wb_we/wb_waddr/wb_wdata drive the register file write port (we/waddr/wdata) directly.

Parameters:
- TIMEOUT, 0, maximum cycles in BUSY without mem_ack before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction present from execute
- in_wreg  in  1  instruction writes a register
- in_waddr  in  5  destination register
- in_wdata  in  32  ALU result (non-load writeback value)
- in_memop  in  4  memory operation: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; other codes are treated as none
- in_maddr  in  32  effective byte address
- in_sdata  in  32  store data
- stall_req  out  1  upstream must hold its outputs this cycle
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address (low 2 bits forced to 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data, replicated into lanes
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  bus completion, single-cycle pulse
- wb_we  out  1  register file write enable
- wb_waddr  out  5  register file write address
- wb_wdata  out  32  register file write data
- exc_misalign  out  1  one-cycle pulse: misaligned access
- exc_buserr  out  1  one-cycle pulse: bus timeout
- exc_badaddr  out  32  faulting address, held until the next exception

Behaviour:
- Async reset: state IDLE; all outputs 0; timeout counter 0.
- States: IDLE, BUSY.
- IDLE, in_valid, memop none: next edge sets wb_we=in_wreg, wb_waddr, wb_wdata=in_wdata. No stall. Latency 1.
- IDLE, in_valid=0: next edge sets wb_we=0.
- IDLE, in_valid, aligned memop:
  - stall_req=1 combinationally.
  - Capture memop, address, sdata, waddr, wreg; go to BUSY; wb_we=0.
- Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - No bus access, no stall.
  - Next edge: exc_misalign=1, exc_badaddr=in_maddr, wb_we=0.
- BUSY:
  - Drives mem_req=1 and holds mem_we/mem_addr/mem_be/mem_wdata stable until ack.
  - stall_req=!mem_ack, so upstream advances on the ack edge.
  - Bubble (wb_we=0) each BUSY cycle.
- BUSY with mem_ack:
  - Return to IDLE.
  - Load: next edge wb_we=wreg, wb_wdata=extracted data.
  - Store: wb_we=0.
  - Load latency is 2 cycles minimum (entry edge, then ack edge).
- Byte lanes are little-endian: byte k is at [8k+7:8k].
  - LB/LBU: lane addr[1:0], sign- or zero-extended.
  - LH/LHU: lanes addr[1]*2..+1, sign- or zero-extended.
  - LW: whole word.
- Store enables and data:
  - SB: be=0001<<addr[1:0], data = byte replicated x4.
  - SH: be=0011<<addr[1:0], data = half replicated x2.
  - SW: be=1111.
- Loads drive be=1111.
- Timeout (TIMEOUT>0):
  - Counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: drop mem_req, return to IDLE, stall_req=0 that cycle.
  - Next edge: exc_buserr=1, exc_badaddr=captured address, wb_we=0.
- mem_ack in IDLE is ignored.
- Reset mid-transaction drops mem_req immediately. A late ack after reset is ignored.
- Exception pulses last exactly one cycle.
- wb_waddr=0 is passed through unchanged; the register file discards writes to register 0.

Test Plan:
- ALU op: in_wreg=1, waddr=5, wdata=0x1234 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x1234; stall_req never asserted.
- LB addr=0x103, ack after 3 BUSY cycles with rdata=0x80FF_0000 -> mem_addr=0x100, be=1111; stall_req high until the ack cycle; then wb_wdata=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH addr=0x22, sdata=0xABCD_5678 -> mem_we=1, be=1100, mem_wdata=0x5678_5678; no wb_we after ack.
- LW addr=0x2 -> no mem_req, no stall; next cycle exc_misalign=1, exc_badaddr=0x2, wb_we=0.
- TIMEOUT=4, LW with no ack -> mem_req high 4 cycles then low; exc_buserr pulses once; stall released; a following ALU op writes back normally.
- Assert rst while in BUSY -> mem_req=0 and stall_req=0 immediately; ack after reset release is ignored; wb_we stays 0.
